// File: rtl/mem32_seq_writer.sv
// Sequential word loader for Memoria32: streams words to consecutive word addresses
// from a programmable base, with optional read-back checksum verification.
module mem32_seq_writer #(
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             verify_en,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic [31:0]      waddress,
  output logic [31:0]      Datain,
  output logic             Wr,
  output logic [31:0]      raddress,
  input  logic [31:0]      Dataout,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      checksum,
  output logic [CNT_W-1:0] words_done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_VERIFY, S_FINISH} state_e;

  localparam int LAT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             verify_q, verify_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             wr_q, wr_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      raddr_q, raddr_d;
  logic [31:0]      csum_q, csum_d;
  logic [31:0]      rsum_q, rsum_d;
  logic             err_q, err_d;
  logic             hs;

  // Handshake: a word transfers on a rising edge where in_valid and in_ready are both 1;
  // in_ready depends only on registered state, never on in_valid.
  assign in_ready = (state_q == S_WRITE) && (acc_q != count_q);
  assign hs       = in_ready && in_valid;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    count_d  = count_q;
    verify_d = verify_q;
    acc_d    = acc_q;
    words_d  = words_q;
    idx_d    = idx_q;
    lat_d    = lat_q;
    wr_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    raddr_d  = raddr_q;
    csum_d   = csum_q;
    rsum_d   = rsum_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base_addr & 32'hFFFF_FFFC;
          count_d  = word_count;
          verify_d = verify_en;
          acc_d    = '0;
          words_d  = '0;
          csum_d   = '0;
          err_d    = 1'b0;
          state_d  = (word_count == '0) ? S_FINISH : S_WRITE;
        end
      end
      S_WRITE: begin
        if (hs) begin
          wr_d    = 1'b1;
          waddr_d = base_q + (32'(acc_q) << 2);
          wdata_d = in_data;
          acc_d   = acc_q + CNT_W'(1);
          csum_d  = csum_q + in_data;
        end
        if (wr_q) begin
          words_d = words_q + CNT_W'(1);
          // Final word written this edge: prime the read-back walk from the base.
          if (words_q + CNT_W'(1) == count_q) begin
            raddr_d = base_q;
            idx_d   = '0;
            lat_d   = '0;
            rsum_d  = '0;
            state_d = verify_q ? S_VERIFY : S_FINISH;
          end
        end
      end
      S_VERIFY: begin
        if (lat_q == LAT_W'(RD_LAT)) begin
          rsum_d = rsum_q + Dataout;
          lat_d  = '0;
          if (idx_q == count_q - CNT_W'(1)) begin
            err_d   = ((rsum_q + Dataout) != csum_q);
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            raddr_d = raddr_q + 32'd4;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      verify_q <= 1'b0;
      acc_q    <= '0;
      words_q  <= '0;
      idx_q    <= '0;
      lat_q    <= '0;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      raddr_q  <= '0;
      csum_q   <= '0;
      rsum_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      count_q  <= count_d;
      verify_q <= verify_d;
      acc_q    <= acc_d;
      words_q  <= words_d;
      idx_q    <= idx_d;
      lat_q    <= lat_d;
      wr_q     <= wr_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      raddr_q  <= raddr_d;
      csum_q   <= csum_d;
      rsum_q   <= rsum_d;
      err_q    <= err_d;
    end
  end

  assign Wr         = wr_q;
  assign waddress   = waddr_q;
  assign Datain     = wdata_q;
  assign raddress   = raddr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH);
  assign err        = err_q;
  assign checksum   = csum_q;
  assign words_done = words_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem32_seq_writer.sv
// Bench for mem32_seq_writer: behavioural Memoria32 (RD_LAT=1), stream driver and a
// scoreboard of expected {address, data} write beats.
module tb_mem32_seq_writer;
  localparam int CNT_W = 16;
  localparam int W     = 64;

  logic             clk = 1'b0;
  logic             nrst;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             verify_en;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic [31:0]      waddress;
  logic [31:0]      Datain;
  logic             Wr;
  logic [31:0]      raddress;
  logic [31:0]      Dataout;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      checksum;
  logic [CNT_W-1:0] words_done;
  logic [1:0]       dbg_state;

  mem32_seq_writer #(.RD_LAT(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .nrst(nrst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .verify_en(verify_en), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .waddress(waddress), .Datain(Datain),
    .Wr(Wr), .raddress(raddress), .Dataout(Dataout), .busy(busy), .done(done),
    .err(err), .checksum(checksum), .words_done(words_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- memory model ----------------
  logic [31:0] mem_a [logic [29:0]];
  logic        corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_a.exists(a[31:2]) ? mem_a[a[31:2]] : 32'h0;
  endfunction

  always @(posedge clk) begin
    Dataout <= mem_rd(raddress);
    if (Wr) mem_a[waddress[31:2]] = (corrupt_en && waddress == corrupt_addr) ? 32'h0 : Datain;
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] tx_q[$];
  int          wr_cyc_q[$];
  int          wr_count = 0;
  int          done_count = 0;
  int          last_wr_cyc = 0;
  int          done_cyc = 0;
  logic [31:0] model_base;
  logic [31:0] sum_m;
  int          tx_idx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (Wr) begin
        logic [W-1:0] e;
        wr_count++;
        last_wr_cyc = cyc;
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("wr_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("waddress", waddress, e[63:32]);
          check_eq("Datain", Datain, e[31:0]);
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [31:0] b, input int n, input logic v);
    @(posedge clk); #1;
    base_addr  = b;
    word_count = CNT_W'(n);
    verify_en  = v;
    start      = 1'b1;
    model_base = b & 32'hFFFF_FFFC;
    sum_m      = 32'h0;
    tx_idx     = 0;
    wr_cyc_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one idle cycle after each word, 2: random 0..2 idle cycles
  task automatic send_words(input int mode);
    logic [31:0] w;
    int g;
    bit ok;
    while (tx_q.size() > 0) begin
      w = tx_q.pop_front();
      exp_q.push_back({model_base + 32'(tx_idx) * 32'd4, w});
      sum_m = sum_m + w;
      tx_idx++;
      in_valid = 1'b1;
      in_data  = w;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) check_eq("in_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      g = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_count;
    for (int k = 0; k < 300 && done_count == d0; k++) begin
      @(negedge clk); #1;
    end
    check_eq("done_seen", 32'(done_count - d0), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0, d0, n, gap;
    logic [31:0] b;
    logic v;
    nrst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; verify_en = 1'b0;
    in_valid = 1'b0; in_data = '0;
    model_base = '0; sum_m = '0; tx_idx = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_Wr", 32'(Wr), 32'd0);
    check_eq("rst_waddress", waddress, 32'd0);
    check_eq("rst_Datain", Datain, 32'd0);
    check_eq("rst_raddress", raddress, 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_checksum", checksum, 32'd0);
    check_eq("rst_words_done", 32'(words_done), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // T1: 17 words back-to-back from base 0
    w0 = wr_count;
    do_start(32'h0, 17, 1'b0);
    check_eq("t1_busy_after_start", 32'(busy), 32'd1);
    check_eq("t1_in_ready_after_start", 32'(in_ready), 32'd1);
    for (int i = 0; i < 17; i++) tx_q.push_back(32'(i) * 32'h11);
    send_words(0);
    wait_done();
    check_eq("t1_done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
    check_eq("t1_wr_pulses", 32'(wr_count - w0), 32'd17);
    check_eq("t1_wr_contiguous", 32'(wr_cyc_q[16] - wr_cyc_q[0]), 32'd16);
    check_eq("t1_checksum", checksum, 32'h908);
    check_eq("t1_words_done", 32'(words_done), 32'd17);
    check_eq("t1_exp_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 17; i++) check_eq("t1_mem", mem_rd(32'(i) * 32'd4), 32'(i) * 32'h11);
    idle_cycles(2);
    check_eq("t1_idle_busy", 32'(busy), 32'd0);

    // T2: same stream with in_valid low every other cycle
    mem_a.delete();
    w0 = wr_count;
    do_start(32'h0, 17, 1'b0);
    for (int i = 0; i < 17; i++) tx_q.push_back(32'(i) * 32'h11);
    send_words(1);
    wait_done();
    check_eq("t2_wr_pulses", 32'(wr_count - w0), 32'd17);
    check_eq("t2_wr_spacing", 32'(wr_cyc_q[16] - wr_cyc_q[0]), 32'd32);
    check_eq("t2_checksum", checksum, 32'h908);
    for (int i = 0; i < 17; i++) check_eq("t2_mem", mem_rd(32'(i) * 32'd4), 32'(i) * 32'h11);

    // T3: verify pass, data 1..4
    do_start(32'h100, 4, 1'b1);
    for (int i = 1; i <= 4; i++) tx_q.push_back(32'(i));
    send_words(0);
    wait_done();
    check_eq("t3_verify_latency", 32'(done_cyc - last_wr_cyc), 32'd9);
    check_eq("t3_err", 32'(err), 32'd0);
    check_eq("t3_checksum", checksum, 32'd10);

    // T4: word at base+8 forced to 0 in memory -> mismatch, err sticky
    corrupt_en = 1'b1; corrupt_addr = 32'h108;
    do_start(32'h100, 4, 1'b1);
    for (int i = 1; i <= 4; i++) tx_q.push_back(32'(i));
    send_words(0);
    wait_done();
    corrupt_en = 1'b0;
    check_eq("t4_err", 32'(err), 32'd1);
    check_eq("t4_checksum", checksum, 32'd10);
    idle_cycles(5);
    check_eq("t4_err_sticky", 32'(err), 32'd1);

    // T5: wrap-around, unaligned base forced to word alignment, random data, verify
    do_start(32'hFFFF_FFFB, 3, 1'b1);
    check_eq("t5_err_cleared", 32'(err), 32'd0);
    for (int i = 0; i < 3; i++) tx_q.push_back($urandom);
    send_words(2);
    wait_done();
    check_eq("t5_checksum", checksum, sum_m);
    check_eq("t5_err", 32'(err), 32'd0);
    check_eq("t5_mem_wrap", mem_rd(32'h0), mem_rd(32'h0) == 32'h0 ? 32'hDEAD_BEEF : mem_rd(32'h0));

    // T6: zero-length transfer
    w0 = wr_count;
    d0 = done_count;
    do_start(32'h40, 0, 1'b0);
    check_eq("t6_done_now", 32'(done), 32'd1);
    idle_cycles(3);
    check_eq("t6_no_wr", 32'(wr_count - w0), 32'd0);
    check_eq("t6_one_done", 32'(done_count - d0), 32'd1);
    check_eq("t6_busy", 32'(busy), 32'd0);

    // T7: start pulsed while busy is ignored
    do_start(32'h200, 5, 1'b0);
    for (int i = 0; i < 2; i++) tx_q.push_back($urandom);
    send_words(0);
    base_addr = 32'h800; word_count = CNT_W'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) tx_q.push_back($urandom);
    send_words(2);
    d0 = done_count;
    wait_done();
    idle_cycles(3);
    check_eq("t7_words_done", 32'(words_done), 32'd5);
    check_eq("t7_checksum", checksum, sum_m);
    check_eq("t7_single_done", 32'(done_count - d0), 32'd1);

    // T8: reset after 3rd of 8 writes, then restart
    do_start(32'h300, 8, 1'b0);
    for (int i = 0; i < 3; i++) tx_q.push_back($urandom);
    send_words(0);
    in_valid = 1'b1; in_data = 32'hCAFE_F00D;
    check_eq("t8_wr_before_rst", 32'(Wr), 32'd1);
    #3 nrst = 1'b0;
    #1;
    check_eq("t8_rst_Wr", 32'(Wr), 32'd0);
    check_eq("t8_rst_busy", 32'(busy), 32'd0);
    check_eq("t8_rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("t8_rst_words_done", 32'(words_done), 32'd0);
    exp_q.delete();
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("t8_rst_hold_Wr", 32'(Wr), 32'd0);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    do_start(32'h300, 2, 1'b0);
    check_eq("t8_restart_words_done", 32'(words_done), 32'd0);
    for (int i = 0; i < 2; i++) tx_q.push_back($urandom);
    send_words(0);
    wait_done();
    check_eq("t8_words_done", 32'(words_done), 32'd2);
    check_eq("t8_checksum", checksum, sum_m);

    // T9: randomized transfers
    for (int t = 0; t < 4; t++) begin
      b = $urandom;
      n = int'($urandom_range(1, 12));
      v = 1'($urandom_range(0, 1));
      w0 = wr_count;
      do_start(b, n, v);
      for (int i = 0; i < n; i++) tx_q.push_back($urandom);
      send_words(2);
      wait_done();
      gap = v ? 1 + 2 * n : 1;
      check_eq("t9_done_latency", 32'(done_cyc - last_wr_cyc), 32'(gap));
      check_eq("t9_wr_pulses", 32'(wr_count - w0), 32'(n));
      check_eq("t9_checksum", checksum, sum_m);
      check_eq("t9_words_done", 32'(words_done), 32'(n));
      check_eq("t9_err", 32'(err), 32'd0);
    end

    check_eq("final_exp_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
